// File: rtl/regfile_param_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_param_pkg
// Brief    : Shared register-file constants: default geometry and R0..R7 names.
// Revision : 1.0
// ============================================================================
package regfile_param_pkg;

    localparam int c_DATA_W_DEF = 8;
    localparam int c_ADDR_W_DEF = 3;

    typedef logic [c_ADDR_W_DEF-1:0] reg_name_t;

    localparam reg_name_t c_R0 = 3'd0;
    localparam reg_name_t c_R1 = 3'd1;
    localparam reg_name_t c_R2 = 3'd2;
    localparam reg_name_t c_R3 = 3'd3;
    localparam reg_name_t c_R4 = 3'd4;
    localparam reg_name_t c_R5 = 3'd5;
    localparam reg_name_t c_R6 = 3'd6;
    localparam reg_name_t c_R7 = 3'd7;

endpackage
`default_nettype wire

// File: rtl/regfile_param_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_param_if
// Brief    : Read/write/reserve bus between the controller and the register file.
// Revision : 1.0
// ============================================================================
interface regfile_param_if
    import regfile_param_pkg::*;
#(
    parameter int DATA_W = c_DATA_W_DEF,
    parameter int ADDR_W = c_ADDR_W_DEF
) ();

    logic [ADDR_W-1:0] AA;
    logic [ADDR_W-1:0] BA;
    logic [ADDR_W-1:0] DA;
    logic [DATA_W-1:0] DataIn;
    logic              WR;
    logic [ADDR_W-1:0] RA;
    logic              RSV;
    logic [DATA_W-1:0] DataA;
    logic [DATA_W-1:0] DataB;
    logic              BusyA;
    logic              BusyB;
    logic              BusyAny;

    modport master (
        output AA, BA, DA, DataIn, WR, RA, RSV,
        input  DataA, DataB, BusyA, BusyB, BusyAny
    );

    modport slave (
        input  AA, BA, DA, DataIn, WR, RA, RSV,
        output DataA, DataB, BusyA, BusyB, BusyAny
    );

endinterface
`default_nettype wire

// File: rtl/regfile_param_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_param_scoreboard
// Brief    : Per-register pending-write busy bits; reserve beats completion.
// Revision : 1.0
// ============================================================================
module regfile_param_scoreboard
    import regfile_param_pkg::*;
#(
    parameter int ADDR_W   = c_ADDR_W_DEF,
    parameter int ZERO_REG = 1
) (
    input  wire logic                   Clk,
    input  wire logic                   Reset,
    input  wire logic [ADDR_W-1:0]      i_ra,
    input  wire logic                   i_rsv,
    input  wire logic [ADDR_W-1:0]      i_da,
    input  wire logic                   i_wr,
    output logic [(1<<ADDR_W)-1:0]      o_busy,
    output logic                        o_busy_any
);

    localparam int c_DEPTH = 1 << ADDR_W;

    logic [c_DEPTH-1:0] r_busy;
    logic [c_DEPTH-1:0] w_busy_nxt;
    logic               w_rsv_ok;

    assign w_rsv_ok = i_rsv && !((ZERO_REG != 0) && (i_ra == '0));

    // Clear first, then set: a new reservation supersedes the write completing now.
    always_comb begin
        w_busy_nxt = r_busy;
        if (i_wr) begin
            w_busy_nxt[i_da] = 1'b0;
        end
        if (w_rsv_ok) begin
            w_busy_nxt[i_ra] = 1'b1;
        end
    end

    always_ff @(negedge Clk or posedge Reset) begin
        if (Reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign o_busy     = r_busy;
    assign o_busy_any = |r_busy;

endmodule
`default_nettype wire

// File: rtl/regfile_param.sv
`default_nettype none
// ============================================================================
// Module   : regfile_param
// Brief    : Parametrised 2R/1W register file with bypass, zero R0 and busy scoreboard.
// Revision : 1.0
// ============================================================================
module regfile_param
    import regfile_param_pkg::*;
#(
    parameter int DATA_W   = c_DATA_W_DEF,
    parameter int ADDR_W   = c_ADDR_W_DEF,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  wire logic         Clk,
    input  wire logic         Reset,
    regfile_param_if.slave    bus
);

    localparam int c_DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0]  r_mem [c_DEPTH];
    logic [c_DEPTH-1:0] w_busy;
    logic               w_busy_any;
    logic               w_wr_en;
    logic [ADDR_W-1:0]  w_rd_addr [2];
    logic [DATA_W-1:0]  w_rd_data [2];
    logic               w_rd_busy [2];

    assign w_wr_en = bus.WR && !((ZERO_REG != 0) && (bus.DA == '0));

    // Writes land on the falling edge to line up with the datapath writeback.
    always_ff @(negedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[bus.DA] <= bus.DataIn;
        end
    end

    regfile_param_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .Clk        (Clk),
        .Reset      (Reset),
        .i_ra       (bus.RA),
        .i_rsv      (bus.RSV),
        .i_da       (bus.DA),
        .i_wr       (bus.WR),
        .o_busy     (w_busy),
        .o_busy_any (w_busy_any)
    );

    assign w_rd_addr[0] = bus.AA;
    assign w_rd_addr[1] = bus.BA;

    // A forwarded read is no longer waiting on its producer, so it is not busy.
    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic w_zero;
        logic w_fwd;
        assign w_zero = (ZERO_REG != 0) && (w_rd_addr[p] == '0);
        assign w_fwd  = (BYPASS != 0) && bus.WR && (w_rd_addr[p] == bus.DA);
        assign w_rd_data[p] = w_zero ? '0 : (w_fwd ? bus.DataIn : r_mem[w_rd_addr[p]]);
        assign w_rd_busy[p] = w_busy[w_rd_addr[p]] && !w_fwd;
    end

    assign bus.DataA   = w_rd_data[0];
    assign bus.DataB   = w_rd_data[1];
    assign bus.BusyA   = w_rd_busy[0];
    assign bus.BusyB   = w_rd_busy[1];
    assign bus.BusyAny = w_busy_any;

endmodule
`default_nettype wire

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised successor to the 8x8 register file in the datapath.
- Provides configurable data width and depth, two combinational read ports and one write port.
- R0 is optionally hard-wired to zero, and a write-to-read bypass forwards data in the same cycle.
- A per-register busy scoreboard lets the controller stall on reads of registers with a pending write.
- Sits between the control unit/ALU and the writeback mux. Shared constants (R1..R7) come from the common package.

Parameters:
- DATA_W, 8, width of each register in bits.
- ADDR_W, 3, address width; depth = 2**ADDR_W.
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and is never busy; 0 = register 0 is an ordinary register.
- BYPASS, 1, 1 = a read of the address being written this cycle returns DataIn; 0 = a read returns the stored value.

Ports:
- Clk  in  1  system clock; all state updates occur on the negedge, matching datapath write timing.
- Reset  in  1  asynchronous, active-high; clears all registers and busy bits.
- AA  in  ADDR_W  read address, port A.
- BA  in  ADDR_W  read address, port B.
- DA  in  ADDR_W  write address.
- DataIn  in  DATA_W  write data.
- WR  in  1  write enable.
- RA  in  ADDR_W  reserve address; marks a register as having a pending write.
- RSV  in  1  reserve enable.
- DataA  out  DATA_W  read data, port A.
- DataB  out  DATA_W  read data, port B.
- BusyA  out  1  register AA has a pending write.
- BusyB  out  1  register BA has a pending write.
- BusyAny  out  1  OR of all busy bits; controller uses it for drain/flush.

Behaviour:
- Reset (async, any time, including mid-write):
  - All 2**ADDR_W registers go to 0 and all busy bits go to 0 immediately.
  - DataA = DataB = 0 (bypass excepted if WR is high with BYPASS=1). BusyA = BusyB = BusyAny = 0.
  - While Reset is high, no negedge writes or reserves take effect.
- Write: on negedge Clk with WR=1, mem[DA] <= DataIn.
  - With ZERO_REG=1 and DA=0, the write is dropped.
  - Latency: stored value is visible at the read ports from the negedge onward.
- Reads are combinational: DataA = mem[AA], DataB = mem[BA].
  - With ZERO_REG=1 and address 0, the output is 0 regardless of bypass.
- Bypass (BYPASS=1): if WR=1, the read address equals DA, and the register is not the zeroed R0, the output is DataIn. Applies to each port independently.
- Scoreboard, evaluated on negedge Clk:
  - RSV=1 sets busy[RA].
  - WR=1 clears busy[DA].
  - RSV and WR to the same address in the same cycle: busy stays/becomes 1. The reserve wins, since a new pending write supersedes the completing one.
  - RSV and WR to different addresses: both take effect.
  - RSV to an already-busy register: stays busy, no error.
  - WR to a non-busy register: writes normally, busy stays 0.
  - With ZERO_REG=1, a reserve of address 0 is ignored.
- Busy outputs:
  - BusyA = busy[AA] and BusyB = busy[BA], combinational.
  - With BYPASS=1 and WR=1 to the same address, BusyA/BusyB read 0 that cycle, because the data is already being forwarded.
  - BusyAny = |busy.
- Addresses are full-range (ADDR_W bits), so there is no out-of-range case. All ports are 2-state; there is no X on outputs after reset.
- No internal FSM beyond the register array and busy vector. State is (2**ADDR_W)*(DATA_W+1) flops.

Decomposition:
- Shared package: register name constants R0..R7 (for ADDR_W=3), default DATA_W/ADDR_W.
- Natural sub-module: regfile_scoreboard, containing the busy vector and its set/clear/priority logic, parametrised by ADDR_W and ZERO_REG.
- The read muxes and bypass stay in the top module.

Test Plan:
- Async reset: after writing 8'hAA to R3, assert Reset between clock edges -> DataA(AA=3) drops to 0 immediately; BusyAny=0.
- Write then read: WR=1, DA=5, DataIn=8'h04 at negedge; then AA=5, BA=5 -> DataA=DataB=8'h04. With WR=0, DataB for BA=2 = 0.
- ZERO_REG=1: WR=1, DA=0, DataIn=8'hFF, RSV=1, RA=0 -> DataA(AA=0)=0, BusyA=0. Repeat with ZERO_REG=0 -> DataA=8'hFF.
- Bypass: WR=1, DA=2, DataIn=8'h5A, AA=2 before the negedge -> DataA=8'h5A combinationally, BusyA=0. With BYPASS=0 -> old value (0) until the negedge.
- Scoreboard priority:
  - RSV RA=4 at negedge -> BusyA(AA=4)=1, BusyAny=1.
  - Next negedge: RSV RA=4 plus WR DA=4 with DataIn=8'h11 -> mem[4]=8'h11, busy[4] stays 1.
  - Next negedge: WR DA=4 alone -> busy[4]=0, BusyAny=0.
- Parametrisation: DATA_W=16, ADDR_W=4 -> write 16'hBEEF to R15, read it on both ports; R15 reserve/clear behaves as above.
